dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder for the core's data-memory interface. It takes the core's address, write data and write enable, and returns read data in the same cycle, as the single-cycle core requires.
- It contains a word-addressed scratch RAM plus an MMIO page with GPIO, a compare timer and a FIFO-buffered 8N1 UART transmitter.
- It sits beside the core at SoC top level.

Parameters:
- RAM_AW, 8, RAM address width; RAM holds 2**RAM_AW 16-bit words.
- GPIO_W, 16, GPIO width (1..16).
- TX_FIFO_DEPTH, 4, UART TX FIFO entries (power of 2, ≥2).
- BAUD_DIV_RESET, 433, reset value of BAUD_DIV; one bit lasts BAUD_DIV+1 clocks.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dmem_addr  in  16  word address from core
- dmem_data_in  in  16  write data from core
- dmem_we  in  1  write strobe; write commits on the rising clk edge
- dmem_data_out  out  16  combinational read data for dmem_addr
- gpio_in  in  GPIO_W  asynchronous inputs
- gpio_out  out  GPIO_W  registered outputs
- uart_tx  out  1  serial line, idles high
- timer_irq  out  1  equals the STATUS.MATCH sticky bit

Behaviour:
- Decode:
  - dmem_addr[15:12]==4'hF selects MMIO at offset dmem_addr[3:0].
  - All other addresses select RAM index dmem_addr[RAM_AW-1:0] (aliased).
- Reads:
  - Purely combinational, with zero latency.
  - Reads have NO side effects. The core drives the address every cycle, so spurious reads must be harmless.
- RAM: synchronous write, asynchronous read, contents not reset. A read of the address being written in the same cycle returns the old data.
- MMIO map (unlisted offsets read 0, writes ignored):
  - 0x0 GPIO_OUT RW. Reset 0.
  - 0x1 GPIO_IN RO. gpio_in passes through a 2-flop synchronizer; reads are zero-extended. Sync flops reset to 0.
  - 0x2 TIMER_CNT RW. Reset 0.
  - 0x3 TIMER_CMP RW. Reset 16'hFFFF.
  - 0x4 STATUS:
    - bit0 MATCH, W1C sticky.
    - bit1 TX_FULL, RO.
    - bit2 TX_BUSY (FIFO non-empty or FSM not IDLE), RO.
    - bit3 TX_EMPTY, RO.
    - bit4 TX_OVF, W1C sticky.
    - All other bits read 0.
  - 0x5 TX_DATA WO. A write pushes dmem_data_in[7:0]; reads return 0.
  - 0x6 BAUD_DIV RW. Reset BAUD_DIV_RESET.
- Timer:
  - Every cycle: if CNT==CMP, then CNT←0 and MATCH←1; else CNT←CNT+1.
  - A CPU write to TIMER_CNT overrides the increment/wrap that cycle; a match is still evaluated on the pre-write value.
  - When MATCH is set and W1C-cleared in the same cycle, set wins.
- TX FIFO:
  - A push is accepted only if the FIFO was not full at the start of the cycle. Otherwise the byte is dropped and TX_OVF←1; set beats W1C.
  - Push and pop in the same cycle on a non-full FIFO are both performed, and occupancy is unchanged.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into the shift register, load the bit counter with BAUD_DIV, and go to START.
  - START: uart_tx=0 for BAUD_DIV+1 cycles.
  - DATA: 8 bits, LSB first, each for BAUD_DIV+1 cycles.
  - STOP: uart_tx=1 for BAUD_DIV+1 cycles, then IDLE.
  - Back-to-back bytes: the next START begins 1 cycle after STOP ends, because IDLE lasts exactly 1 cycle.
  - BAUD_DIV is sampled at each bit-timer reload, so a mid-frame write takes effect at the next bit boundary.
- Reset: asserting rst_n low mid-frame aborts the frame on that edge.
  - uart_tx←1, FSM←IDLE, FIFO emptied.
  - All registers return to their reset values; RAM is untouched.
- Register widths: all arithmetic is 16-bit unsigned and wraps modulo 2^16.

Decomposition:
- Package dmem_responder_pkg holds:
  - MMIO page constant 4'hF;
  - offset localparams OFS_GPIO_OUT..OFS_BAUD_DIV;
  - STATUS bit indices;
  - TX FSM state encoding.
- One sub-module, dmem_uart_tx, contains the FIFO and serializer, with ports push/push_data/baud_div/full/empty/busy/uart_tx.
- The decode logic, RAM, GPIO and timer stay in the top module.

Test Plan:
- RAM: write 16'hBEEF to 0x0012, then read 0x0012 → 16'hBEEF. Read 0x0112 → 16'hBEEF (alias at RAM_AW=8). Read in the same cycle as the write → old value.
- GPIO:
  - Write 16'h00A5 to 0xF000 → gpio_out==16'h00A5 after the edge.
  - Drive gpio_in=16'h3C3C → a read of 0xF001 returns 16'h3C3C on the 2nd cycle after the change, and the old value before that.
- Timer: write CMP=5, CNT=0 → timer_irq rises the cycle after CNT reaches 5, and CNT reads 0,1,2… afterwards. Write 16'h0001 to 0xF004 → irq falls. W1C coincident with a match → irq stays 1.
- UART frame: BAUD_DIV=3, push 8'h55 → uart_tx shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level held 4 cycles. TX_BUSY=1 throughout, then TX_EMPTY=1.
- FIFO overflow: BAUD_DIV=100, push 6 bytes in consecutive cycles → the first is popped immediately and the next 4 fill the FIFO. The 6th is dropped with TX_OVF=1 and TX_FULL=1. The serial output carries exactly 5 bytes, back-to-back with a 1-cycle IDLE gap.
- Reset mid-frame: pull rst_n low during DATA bit 3 → uart_tx=1, TX_EMPTY=1, GPIO_OUT=0, CMP=16'hFFFF, BAUD_DIV=433 after the edge. RAM contents are preserved.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared constants for the data-memory responder: the MMIO page select,
//   register offsets within that page, STATUS bit positions and the UART
//   transmitter state encoding.
package dmem_responder_pkg;

  // dmem_addr[15:12] value that selects the MMIO page instead of RAM.
  localparam logic [3:0] MMIO_PAGE = 4'hF;

  // Register offsets, taken from dmem_addr[3:0].
  localparam logic [3:0] OFS_GPIO_OUT  = 4'h0;
  localparam logic [3:0] OFS_GPIO_IN   = 4'h1;
  localparam logic [3:0] OFS_TIMER_CNT = 4'h2;
  localparam logic [3:0] OFS_TIMER_CMP = 4'h3;
  localparam logic [3:0] OFS_STATUS    = 4'h4;
  localparam logic [3:0] OFS_TX_DATA   = 4'h5;
  localparam logic [3:0] OFS_BAUD_DIV  = 4'h6;

  // STATUS register bit positions.
  localparam int ST_MATCH    = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx
//   Byte FIFO feeding an 8N1 serializer. Each bit lasts baud_div_i+1 clocks;
//   baud_div_i is sampled whenever the bit timer reloads.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     push_i           push push_data_i this cycle (dropped if full)
//     push_data_i[7:0] byte to enqueue
//     baud_div_i[15:0] bit period minus one
//     full_o, empty_o  FIFO occupancy flags
//     busy_o           FIFO non-empty or frame in progress
//     uart_tx_o        serial line, idles high
//
// Handshake: push_i is a one-cycle strobe with no ready; the caller checks
// full_o in the same cycle to know whether the byte was taken.
module dmem_uart_tx
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [7:0]  push_data_i,
  input  logic [15:0] baud_div_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        busy_o,
  output logic        uart_tx_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_ok, pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign busy_o  = !empty_o || (state_q != TX_IDLE);
  assign push_ok = push_i && !full_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage carries no reset; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= TX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Bit timer counts down from baud_div to 0, so each level lasts
  // baud_div+1 cycles. IDLE always lasts exactly one cycle between frames.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    uart_tx_o  = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (!empty_o) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          baud_cnt_d = baud_div_i;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        uart_tx_o = 1'b0;
        if (baud_cnt_q == '0) begin
          baud_cnt_d = baud_div_i;
          bit_idx_d  = '0;
          state_d    = TX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        uart_tx_o = shift_q[0];
        if (baud_cnt_q == '0) begin
          baud_cnt_d = baud_div_i;
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_cnt_q == '0) state_d = TX_IDLE;
        else                  baud_cnt_d = baud_cnt_q - 16'd1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the single-cycle core: word-addressed scratch
//   RAM plus an MMIO page (GPIO, compare timer, FIFO-buffered UART TX).
//   Reads are combinational and side-effect free; writes commit on clk.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     dmem_addr[15:0]     word address (page 0xF = MMIO, else RAM, aliased)
//     dmem_data_in[15:0]  write data
//     dmem_we             write strobe
//     dmem_data_out[15:0] read data for dmem_addr, same cycle
//     gpio_in, gpio_out   GPIO input (synchronized) / registered output
//     uart_tx             serial output, idles high
//     timer_irq           STATUS.MATCH sticky bit
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          RAM_AW         = 8,
  parameter int          GPIO_W         = 16,
  parameter int          TX_FIFO_DEPTH  = 4,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd433
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       dmem_addr,
  input  logic [15:0]       dmem_data_in,
  input  logic              dmem_we,
  output logic [15:0]       dmem_data_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx,
  output logic              timer_irq
);

  logic [15:0]       ram_q [2**RAM_AW];
  logic [GPIO_W-1:0] gpio_out_q, sync1_q, sync2_q;
  logic [15:0]       cnt_q, cnt_d, cmp_q, baud_q;
  logic              match_q, match_d, ovf_q, ovf_d;

  logic              is_mmio, wr_mmio, cnt_hit, tx_push;
  logic              tx_full, tx_empty, tx_busy;
  logic [3:0]        ofs;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  assign is_mmio = (dmem_addr[15:12] == MMIO_PAGE);
  assign ofs     = dmem_addr[3:0];
  assign ram_idx = dmem_addr[RAM_AW-1:0];
  assign wr_mmio = dmem_we && is_mmio;
  assign tx_push = wr_mmio && (ofs == OFS_TX_DATA);
  assign cnt_hit = (cnt_q == cmp_q);
  // Address bits between the RAM index and the page select are don't-care.
  assign unused_addr_bits = ^dmem_addr;

  assign gpio_out  = gpio_out_q;
  assign timer_irq = match_q;

  // RAM contents survive reset; async read returns pre-write data.
  always_ff @(posedge clk) begin
    if (dmem_we && !is_mmio) ram_q[ram_idx] <= dmem_data_in;
  end

  // Sticky bits: a set event in the same cycle as a W1C wins.
  always_comb begin
    cnt_d = cnt_hit ? 16'd0 : cnt_q + 16'd1;
    if (wr_mmio && ofs == OFS_TIMER_CNT) cnt_d = dmem_data_in;

    match_d = match_q;
    if (wr_mmio && ofs == OFS_STATUS && dmem_data_in[ST_MATCH]) match_d = 1'b0;
    if (cnt_hit) match_d = 1'b1;

    ovf_d = ovf_q;
    if (wr_mmio && ofs == OFS_STATUS && dmem_data_in[ST_TX_OVF]) ovf_d = 1'b0;
    if (tx_push && tx_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      cmp_q      <= 16'hFFFF;
      baud_q     <= BAUD_DIV_RESET;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      if (wr_mmio && ofs == OFS_GPIO_OUT)  gpio_out_q <= dmem_data_in[GPIO_W-1:0];
      if (wr_mmio && ofs == OFS_TIMER_CMP) cmp_q      <= dmem_data_in;
      if (wr_mmio && ofs == OFS_BAUD_DIV)  baud_q     <= dmem_data_in;
    end
  end

  always_comb begin
    dmem_data_out = '0;
    if (is_mmio) begin
      case (ofs)
        OFS_GPIO_OUT:  dmem_data_out[GPIO_W-1:0] = gpio_out_q;
        OFS_GPIO_IN:   dmem_data_out[GPIO_W-1:0] = sync2_q;
        OFS_TIMER_CNT: dmem_data_out = cnt_q;
        OFS_TIMER_CMP: dmem_data_out = cmp_q;
        OFS_STATUS: begin
          dmem_data_out[ST_MATCH]    = match_q;
          dmem_data_out[ST_TX_FULL]  = tx_full;
          dmem_data_out[ST_TX_BUSY]  = tx_busy;
          dmem_data_out[ST_TX_EMPTY] = tx_empty;
          dmem_data_out[ST_TX_OVF]   = ovf_q;
        end
        OFS_BAUD_DIV:  dmem_data_out = baud_q;
        default:       dmem_data_out = '0;
      endcase
    end else begin
      dmem_data_out = ram_q[ram_idx];
    end
  end

  dmem_uart_tx #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tx_push),
    .push_data_i (dmem_data_in[7:0]),
    .baud_div_i  (baud_q),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .busy_o      (tx_busy),
    .uart_tx_o   (uart_tx)
  );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dmem_addr = '0;
  logic [15:0] dmem_data_in = '0;
  logic        dmem_we = 1'b0;
  logic [15:0] dmem_data_out;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic        uart_tx;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  dmem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_addr     (dmem_addr),
    .dmem_data_in  (dmem_data_in),
    .dmem_we       (dmem_we),
    .dmem_data_out (dmem_data_out),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .uart_tx       (uart_tx),
    .timer_irq     (timer_irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    dmem_addr    = a;
    dmem_data_in = d;
    dmem_we      = 1'b1;
    tick();
    dmem_we      = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    dmem_addr = a;
    #1;
    d = dmem_data_out;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] rd;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n_checks++; if (gpio_out !== 16'h0000) begin n_fail++; $display("FAIL rst_gpio_out: got %h want 0000", gpio_out); end
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", timer_irq); end
    bus_read(16'hF004, rd);
    n_checks++; if (rd !== 16'h0008) begin n_fail++; $display("FAIL rst_status: got %h want 0008", rd); end
    bus_read(16'hF003, rd);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL rst_cmp: got %h want ffff", rd); end
    bus_read(16'hF006, rd);
    n_checks++; if (rd !== 16'd433) begin n_fail++; $display("FAIL rst_baud: got %h want 01b1", rd); end
    bus_read(16'hF002, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL rst_cnt: got %h want 0000", rd); end
    bus_read(16'hF007, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read: got %h want 0000", rd); end
    tick();
    bus_read(16'hF002, rd);
    n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL cnt_after_1: got %h want 0001", rd); end
    bus_read(16'hF005, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL tx_data_read: got %h want 0000", rd); end
  endtask

  task automatic test_ram();
    logic [15:0] rd;
    bus_write(16'h0012, 16'h1111);
    bus_write(16'h0013, 16'h2222);
    dmem_addr    = 16'h0012;
    dmem_data_in = 16'hBEEF;
    dmem_we      = 1'b1;
    #1;
    n_checks++; if (dmem_data_out !== 16'h1111) begin n_fail++; $display("FAIL ram_same_cycle: got %h want 1111", dmem_data_out); end
    tick();
    dmem_we = 1'b0;
    bus_read(16'h0012, rd);
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL ram_read: got %h want beef", rd); end
    bus_read(16'h0112, rd);
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL ram_alias: got %h want beef", rd); end
    bus_read(16'h0013, rd);
    n_checks++; if (rd !== 16'h2222) begin n_fail++; $display("FAIL ram_neighbour: got %h want 2222", rd); end
  endtask

  task automatic test_gpio();
    logic [15:0] rd;
    bus_write(16'hF000, 16'h00A5);
    n_checks++; if (gpio_out !== 16'h00A5) begin n_fail++; $display("FAIL gpio_out: got %h want 00a5", gpio_out); end
    bus_read(16'hF000, rd);
    n_checks++; if (rd !== 16'h00A5) begin n_fail++; $display("FAIL gpio_out_read: got %h want 00a5", rd); end
    gpio_in = 16'h3C3C;
    bus_read(16'hF001, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL gpio_in_c0: got %h want 0000", rd); end
    tick();
    bus_read(16'hF001, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL gpio_in_c1: got %h want 0000", rd); end
    tick();
    bus_read(16'hF001, rd);
    n_checks++; if (rd !== 16'h3C3C) begin n_fail++; $display("FAIL gpio_in_c2: got %h want 3c3c", rd); end
  endtask

  task automatic test_timer();
    logic [15:0] rd;
    bus_write(16'hF003, 16'd5);
    bus_write(16'hF002, 16'd0);
    for (int i = 0; i <= 5; i++) begin
      bus_read(16'hF002, rd);
      n_checks++; if (rd !== 16'(i)) begin n_fail++; $display("FAIL timer_cnt_%0d: got %h want %h", i, rd, 16'(i)); end
      n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_low_%0d: got %b want 0", i, timer_irq); end
      tick();
    end
    for (int i = 0; i <= 2; i++) begin
      bus_read(16'hF002, rd);
      n_checks++; if (rd !== 16'(i)) begin n_fail++; $display("FAIL timer_wrap_%0d: got %h want %h", i, rd, 16'(i)); end
      n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL timer_irq_high_%0d: got %b want 1", i, timer_irq); end
      if (i < 2) tick();
    end
    bus_write(16'hF004, 16'h0001);
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_w1c: got %b want 0", timer_irq); end
    tick();
    tick();
    bus_read(16'hF002, rd);
    n_checks++; if (rd !== 16'd5) begin n_fail++; $display("FAIL timer_pre_coinc: got %h want 0005", rd); end
    bus_write(16'hF004, 16'h0001);
    n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL timer_set_beats_w1c: got %b want 1", timer_irq); end
    bus_read(16'hF002, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL timer_coinc_wrap: got %h want 0000", rd); end
  endtask

  task automatic test_uart_frame();
    logic [15:0] rd;
    logic [9:0]  frame;
    frame = {1'b1, 8'h55, 1'b0};
    bus_write(16'hF006, 16'd3);
    bus_read(16'hF006, rd);
    n_checks++; if (rd !== 16'd3) begin n_fail++; $display("FAIL baud_write: got %h want 0003", rd); end
    bus_write(16'hF005, 16'h0055);
    bus_read(16'hF004, rd);
    n_checks++; if ((rd & 16'h001E) !== 16'h0004) begin n_fail++; $display("FAIL frame_queued_status: got %h want 0004", rd & 16'h001E); end
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL frame_idle: got %b want 1", uart_tx); end
    tick();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_checks++; if (uart_tx !== frame[b]) begin n_fail++; $display("FAIL frame_bit%0d_cyc%0d: got %b want %b", b, c, uart_tx, frame[b]); end
        bus_read(16'hF004, rd);
        n_checks++; if (rd[2] !== 1'b1) begin n_fail++; $display("FAIL frame_busy_bit%0d_cyc%0d: got %b want 1", b, c, rd[2]); end
        tick();
      end
    end
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL frame_end_line: got %b want 1", uart_tx); end
    bus_read(16'hF004, rd);
    n_checks++; if ((rd & 16'h001E) !== 16'h0008) begin n_fail++; $display("FAIL frame_end_status: got %h want 0008", rd & 16'h001E); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0]  bytes [6];
    logic [15:0] rd;
    logic [9:0]  frame;
    logic [7:0]  b;
    int          p0, start, low_seen;
    bytes[0] = 8'h11; bytes[1] = 8'hA3; bytes[2] = 8'h5C;
    bytes[3] = 8'hF0; bytes[4] = 8'h0F; bytes[5] = 8'h99;
    bus_write(16'hF006, 16'd100);
    exp_q.delete();
    p0 = cyc;
    for (int i = 0; i < 6; i++) begin
      dmem_addr    = 16'hF005;
      dmem_data_in = {8'h00, bytes[i]};
      dmem_we      = 1'b1;
      if (i < 5) exp_q.push_back(bytes[i]);
      tick();
    end
    dmem_we = 1'b0;
    bus_read(16'hF004, rd);
    n_checks++; if ((rd & 16'h001E) !== 16'h0016) begin n_fail++; $display("FAIL ovf_status: got %h want 0016", rd & 16'h001E); end
    bus_write(16'hF004, 16'h0010);
    bus_read(16'hF004, rd);
    n_checks++; if ((rd & 16'h001E) !== 16'h0006) begin n_fail++; $display("FAIL ovf_w1c: got %h want 0006", rd & 16'h001E); end
    for (int k = 0; k < 5; k++) begin
      start = p0 + 2 + k * 1011;
      b     = exp_q.pop_front();
      frame = {1'b1, b, 1'b0};
      if (k > 0) begin
        while (cyc < start - 1) tick();
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL ovf_gap_f%0d: got %b want 1", k, uart_tx); end
        tick();
        n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL ovf_start_edge_f%0d: got %b want 0", k, uart_tx); end
      end
      for (int j = 0; j < 10; j++) begin
        while (cyc < start + j * 101 + 50) tick();
        n_checks++; if (uart_tx !== frame[j]) begin n_fail++; $display("FAIL ovf_f%0d_bit%0d: got %b want %b", k, j, uart_tx, frame[j]); end
      end
      while (cyc < start + 1009) tick();
      n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL ovf_stop_end_f%0d: got %b want 1", k, uart_tx); end
    end
    low_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (uart_tx !== 1'b1) low_seen++;
    end
    n_checks++; if (low_seen != 0) begin n_fail++; $display("FAIL ovf_no_sixth_byte: got %0d low cycles want 0", low_seen); end
    bus_read(16'hF004, rd);
    n_checks++; if ((rd & 16'h001E) !== 16'h0008) begin n_fail++; $display("FAIL ovf_drained_status: got %h want 0008", rd & 16'h001E); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rd;
    int          p0, low_seen;
    bus_write(16'h0040, 16'hCAFE);
    bus_write(16'hF000, 16'h005A);
    p0 = cyc;
    bus_write(16'hF005, 16'h00F0);
    bus_write(16'hF005, 16'h0012);
    bus_write(16'hF005, 16'h0034);
    while (cyc < p0 + 2 + 4 * 101 + 10) tick();
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3_before_rst: got %b want 0", uart_tx); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_line: got %b want 1", uart_tx); end
    n_checks++; if (gpio_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_gpio: got %h want 0000", gpio_out); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq: got %b want 0", timer_irq); end
    bus_read(16'hF004, rd);
    n_checks++; if (rd !== 16'h0008) begin n_fail++; $display("FAIL mid_rst_status: got %h want 0008", rd); end
    bus_read(16'hF003, rd);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL mid_rst_cmp: got %h want ffff", rd); end
    bus_read(16'hF006, rd);
    n_checks++; if (rd !== 16'd433) begin n_fail++; $display("FAIL mid_rst_baud: got %h want 01b1", rd); end
    bus_read(16'hF001, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_sync: got %h want 0000", rd); end
    bus_read(16'h0040, rd);
    n_checks++; if (rd !== 16'hCAFE) begin n_fail++; $display("FAIL mid_rst_ram40: got %h want cafe", rd); end
    bus_read(16'h0012, rd);
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL mid_rst_ram12: got %h want beef", rd); end
    rst_n = 1'b1;
    low_seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (uart_tx !== 1'b1) low_seen++;
    end
    n_checks++; if (low_seen != 0) begin n_fail++; $display("FAIL mid_rst_fifo_flushed: got %0d low cycles want 0", low_seen); end
    bus_read(16'hF001, rd);
    n_checks++; if (rd !== 16'h3C3C) begin n_fail++; $display("FAIL mid_rst_gpio_in: got %h want 3c3c", rd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_uart_frame();
    test_fifo_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
